branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating-counter direction prediction for the 5-stage RV32 pipeline.
- Sits beside the PC and drives the Predict_Target_pc / BP_taken inputs that are currently tied off.
- IF performs a same-cycle lookup.
- EXE writes back resolved outcomes; the block reports mispredicts and keeps performance counters.

Parameters:
- ADDR_WIDTH, 16: PC / target width (matches memAddrWidth).
- ENTRIES, 16: number of BTB entries; power of two, ≥2.
- CNT_BITS, 2: direction counter width, 1..4.
- PERF_WIDTH, 32: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- IF_pc  in  ADDR_WIDTH  fetch PC being looked up.
- BP_taken  out  1  prediction taken (combinational from IF_pc).
- Predict_Target_pc  out  ADDR_WIDTH  predicted target; 0 when BP_taken=0.
- upd_valid  in  1  resolved branch/jump in EXE this cycle (already qualified by stall/flush).
- upd_pc  in  ADDR_WIDTH  PC of resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_WIDTH  actual target.
- upd_pred_taken  in  1  prediction carried down the pipe for this instruction.
- upd_pred_target  in  ADDR_WIDTH  predicted target carried down the pipe.
- mispredict  out  1  combinational: upd_valid && (upd_taken!=upd_pred_taken || (upd_taken && upd_target!=upd_pred_target)).
- bp_clear  in  1  synchronous invalidate of all entries.
- perf_branches  out  PERF_WIDTH  count of upd_valid cycles.
- perf_mispred  out  PERF_WIDTH  count of mispredict cycles.

Behaviour:
- IDX_W = log2(ENTRIES).
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_WIDTH-1:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target[ADDR_WIDTH], cnt[CNT_BITS].
- Lookup (combinational, zero latency):
  - hit = valid && tag match.
  - BP_taken = hit && cnt[MSB].
  - Predict_Target_pc = BP_taken ? target : 0.
- Update on rising edge when upd_valid=1:
  - Hit, taken: cnt saturating +1 (stays at all-ones); target <= upd_target.
  - Hit, not taken: cnt saturating −1 (stays at 0); target unchanged.
  - Miss, taken: allocate/overwrite the indexed entry. valid=1, tag=new, target=upd_target, cnt = 1<<(CNT_BITS-1) (weakly taken).
  - Miss, not taken: no state change.
- Read-before-write: a lookup and an update to the same index in the same cycle returns the pre-update entry. The new value is visible from the next cycle.
- bp_clear:
  - Clears all valid bits at the next edge.
  - Overrides a same-cycle update, so no entry is written.
  - perf counters are not affected.
- Perf counters:
  - perf_branches +1 per upd_valid cycle.
  - perf_mispred +1 per mispredict cycle.
  - Both saturate at all-ones and do not wrap.
- Reset (rst=0, asynchronous):
  - All valid=0, cnt=0, target=0, tag=0, perf counters=0.
  - Hence BP_taken=0, Predict_Target_pc=0, and mispredict=0 unless upd_valid.
- Reset mid-update: reset wins; the in-flight update is discarded.
- Storage: flop array, no SRAM macro; ENTRIES×(1+TAG+ADDR_WIDTH+CNT_BITS) bits.

Decomposition:
- Package bp_pkg:
  - index/tag width helper functions (clog2-based).
  - counter init constant (weakly taken).
  - counter saturation limits.
- Sub-module sat_counter: CNT_BITS-wide saturating up/down next-value logic.
  - Combinational, instantiated per update path.
  - Also reused, with PERF_WIDTH, for the up-only perf counters.

Test Plan:
- Reset then lookup IF_pc=0x0040 → BP_taken=0, Predict_Target_pc=0x0000, both perf counters 0.
- Update pc=0x0040, taken, target=0x0100, pred_taken=0.
  - mispredict=1, perf_mispred=1.
  - Next cycle, lookup 0x0040 → BP_taken=1, target 0x0100, cnt=2'b10.
- Two not-taken updates to 0x0040 from cnt=2'b10.
  - After the first: cnt=01, BP_taken=0.
  - After the second: cnt=00.
  - A third: cnt stays 00.
  - Three taken updates then saturate cnt at 11.
- Aliasing: with ENTRIES=16, pc=0x0040 allocated, then taken update pc=0x0080 (same index, different tag).
  - Entry overwritten; lookup 0x0040 → miss (BP_taken=0).
  - Lookup 0x0080 → hit, taken.
- Same-cycle lookup and update of index 5 (allocate, taken) → that cycle BP_taken=0; following cycle BP_taken=1.
- bp_clear asserted together with upd_valid (taken, new pc) → all lookups miss next cycle, perf_branches still increments.
  - Separately: with PERF_WIDTH=4, 16+ updates hold perf_branches at 4'hF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared sizing helpers and counter constants for the branch target predictor.
package bp_pkg;

    function automatic int idxWidth(input int entries);
        return $clog2(entries);
    endfunction

    // Tag is whatever PC bits remain above the index and the ignored byte offset.
    function automatic int tagWidth(input int addrWidth, input int entries);
        return addrWidth - $clog2(entries) - 2;
    endfunction

    function automatic int cntInit(input int cntBits);
        return 1 << (cntBits - 1);
    endfunction

    function automatic int cntMax(input int cntBits);
        return (1 << cntBits) - 1;
    endfunction

    localparam int CNT_MIN = 0;

endpackage

// File: rtl/sat_counter.sv
// Combinational saturating up/down next-value logic; inc has priority over dec.
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != '1) nxt = cur + WIDTH'(1);
        end else if (dec) begin
            if (cur != '0) nxt = cur - WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, zero-latency
// lookup for IF, resolved-outcome update from EXE and saturating perf counters.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int ENTRIES    = 16,
    parameter int CNT_BITS   = 2,
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] IF_pc,
    output logic                  BP_taken,
    output logic [ADDR_WIDTH-1:0] Predict_Target_pc,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  mispredict,
    input  logic                  bp_clear,
    output logic [PERF_WIDTH-1:0] perf_branches,
    output logic [PERF_WIDTH-1:0] perf_mispred
);

    localparam int IDX_W = idxWidth(ENTRIES);
    localparam int TAG_W = tagWidth(ADDR_WIDTH, ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(cntInit(CNT_BITS));

    logic                  validMem  [ENTRIES];
    logic [TAG_W-1:0]      tagMem    [ENTRIES];
    logic [ADDR_WIDTH-1:0] targetMem [ENTRIES];
    logic [CNT_BITS-1:0]   cntMem    [ENTRIES];

    logic [IDX_W-1:0]      ifIdx, updIdx;
    logic [TAG_W-1:0]      ifTag, updTag;
    logic                  ifHit, updHit;
    logic [CNT_BITS-1:0]   cntNext;
    logic [PERF_WIDTH-1:0] branchesNext, mispredNext;
    logic                  unusedPcBits;

    // Instructions are word aligned, so the byte offset never selects anything.
    assign unusedPcBits = ^{IF_pc[1:0], upd_pc[1:0]};

    assign ifIdx  = IF_pc[IDX_W+1:2];
    assign ifTag  = IF_pc[ADDR_WIDTH-1:IDX_W+2];
    assign updIdx = upd_pc[IDX_W+1:2];
    assign updTag = upd_pc[ADDR_WIDTH-1:IDX_W+2];

    assign ifHit             = validMem[ifIdx] && (tagMem[ifIdx] == ifTag);
    assign BP_taken          = ifHit && cntMem[ifIdx][CNT_BITS-1];
    assign Predict_Target_pc = BP_taken ? targetMem[ifIdx] : '0;

    assign updHit     = validMem[updIdx] && (tagMem[updIdx] == updTag);
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    sat_counter #(.WIDTH(CNT_BITS)) dirCounter (
        .cur (cntMem[updIdx]),
        .inc (upd_taken),
        .dec (!upd_taken),
        .nxt (cntNext)
    );

    sat_counter #(.WIDTH(PERF_WIDTH)) branchCounter (
        .cur (perf_branches),
        .inc (upd_valid),
        .dec (1'b0),
        .nxt (branchesNext)
    );

    sat_counter #(.WIDTH(PERF_WIDTH)) mispredCounter (
        .cur (perf_mispred),
        .inc (mispredict),
        .dec (1'b0),
        .nxt (mispredNext)
    );

    // Lookups read the array combinationally, so a same-cycle update to the
    // same index is only visible after this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validMem[i]  <= 1'b0;
                tagMem[i]    <= '0;
                targetMem[i] <= '0;
                cntMem[i]    <= '0;
            end
        end else if (bp_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validMem[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (updHit) begin
                cntMem[updIdx] <= cntNext;
                if (upd_taken) targetMem[updIdx] <= upd_target;
            end else if (upd_taken) begin
                validMem[updIdx]  <= 1'b1;
                tagMem[updIdx]    <= updTag;
                targetMem[updIdx] <= upd_target;
                cntMem[updIdx]    <= CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else begin
            perf_branches <= branchesNext;
            perf_mispred  <= mispredNext;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed vector table plus randomized traffic against a behavioural BTB model.
module tb_branch_target_predictor;

    localparam int ENT  = 16;
    localparam int IDXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ifPc, updPc, updTarget, updPredTarget;
    logic        updValid, updTaken, updPredTaken, bpClear;

    logic        bpTaken, mispredict;
    logic [15:0] predTarget;
    logic [31:0] perfBr, perfMis;
    logic        bpTaken4, mispredict4;
    logic [15:0] predTarget4;
    logic [3:0]  perfBr4, perfMis4;

    always #5 clk = ~clk;

    branch_target_predictor dut (
        .clk(clk), .rst(rst), .IF_pc(ifPc), .BP_taken(bpTaken),
        .Predict_Target_pc(predTarget), .upd_valid(updValid), .upd_pc(updPc),
        .upd_taken(updTaken), .upd_target(updTarget), .upd_pred_taken(updPredTaken),
        .upd_pred_target(updPredTarget), .mispredict(mispredict), .bp_clear(bpClear),
        .perf_branches(perfBr), .perf_mispred(perfMis)
    );

    branch_target_predictor #(.PERF_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .IF_pc(ifPc), .BP_taken(bpTaken4),
        .Predict_Target_pc(predTarget4), .upd_valid(updValid), .upd_pc(updPc),
        .upd_taken(updTaken), .upd_target(updTarget), .upd_pred_taken(updPredTaken),
        .upd_pred_target(updPredTarget), .mispredict(mispredict4), .bp_clear(bpClear),
        .perf_branches(perfBr4), .perf_mispred(perfMis4)
    );

    // Behavioural model: one record per BTB slot, counters as plain integers.
    bit     mValid  [ENT];
    int     mTag    [ENT];
    int     mTarget [ENT];
    int     mCnt    [ENT];
    longint mBr, mMis, mBr4, mMis4;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [15:0] ifPc;
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic        upt;
        logic [15:0] uptgt;
        logic        clr;
        logic        expBp;
        logic [15:0] expTgt;
        logic        expMisp;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int idxOf(input int pc);
        return (pc >> 2) % ENT;
    endfunction

    function automatic int tagOf(input int pc);
        return pc >> (IDXW + 2);
    endfunction

    function automatic longint satInc(input longint v, input longint maxV);
        return (v < maxV) ? v + 1 : v;
    endfunction

    task automatic modelLookup(input int pc, output bit taken, output int tgt);
        int i;
        i     = idxOf(pc);
        taken = mValid[i] && (mTag[i] == tagOf(pc)) && (mCnt[i] >= 2);
        tgt   = taken ? mTarget[i] : 0;
    endtask

    function automatic bit modelMisp();
        return updValid && ((updTaken != updPredTaken) ||
                            (updTaken && (updTarget != updPredTarget)));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENT; i++) begin
            mValid[i] = 1'b0; mTag[i] = 0; mTarget[i] = 0; mCnt[i] = 0;
        end
        mBr = 0; mMis = 0; mBr4 = 0; mMis4 = 0;
    endtask

    task automatic modelClock(input bit misp);
        int  i;
        bit  hit;
        if (updValid) begin
            mBr  = satInc(mBr, 64'hFFFF_FFFF);
            mBr4 = satInc(mBr4, 15);
        end
        if (misp) begin
            mMis  = satInc(mMis, 64'hFFFF_FFFF);
            mMis4 = satInc(mMis4, 15);
        end
        i   = idxOf(int'(updPc));
        hit = mValid[i] && (mTag[i] == tagOf(int'(updPc)));
        if (bpClear) begin
            for (int k = 0; k < ENT; k++) mValid[k] = 1'b0;
        end else if (updValid) begin
            if (hit && updTaken) begin
                mCnt[i]    = (mCnt[i] < 3) ? mCnt[i] + 1 : 3;
                mTarget[i] = int'(updTarget);
            end else if (hit) begin
                mCnt[i] = (mCnt[i] > 0) ? mCnt[i] - 1 : 0;
            end else if (updTaken) begin
                mValid[i]  = 1'b1;
                mTag[i]    = tagOf(int'(updPc));
                mTarget[i] = int'(updTarget);
                mCnt[i]    = 2;
            end
        end
    endtask

    task automatic checkOutputs(input string lbl);
        bit t;
        int tg;
        modelLookup(int'(ifPc), t, tg);
        check({lbl, ".taken"},    64'(bpTaken),    64'(t));
        check({lbl, ".target"},   64'(predTarget), 64'(tg));
        check({lbl, ".misp"},     64'(mispredict), 64'(modelMisp()));
        check({lbl, ".perfBr"},   64'(perfBr),     64'(mBr));
        check({lbl, ".perfMis"},  64'(perfMis),    64'(mMis));
        check({lbl, ".perfBr4"},  64'(perfBr4),    64'(mBr4));
        check({lbl, ".perfMis4"}, 64'(perfMis4),   64'(mMis4));
    endtask

    // Called #1 after a falling edge with inputs already stable.
    task automatic checkAndClock(input string lbl);
        bit misp;
        checkOutputs(lbl);
        misp = modelMisp();
        @(posedge clk);
        modelClock(misp);
        @(negedge clk);
    endtask

    function automatic logic [15:0] randPc();
        return 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        bit pt;
        int ptg;

        vecs[0]  = '{16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0};
        vecs[3]  = '{16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b1};
        vecs[4]  = '{16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[7]  = '{16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[8]  = '{16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b0};
        vecs[9]  = '{16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b0};
        vecs[10] = '{16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b1};
        vecs[11] = '{16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0};
        vecs[12] = '{16'h0080, 1'b1, 16'h0080, 1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[13] = '{16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[14] = '{16'h0080, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 1'b0};
        vecs[15] = '{16'h0014, 1'b1, 16'h0014, 1'b1, 16'h0300, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[16] = '{16'h0014, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0300, 1'b0};
        vecs[17] = '{16'h0014, 1'b1, 16'h0014, 1'b1, 16'h0304, 1'b1, 16'h0300, 1'b0, 1'b1, 16'h0300, 1'b1};
        vecs[18] = '{16'h0014, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0304, 1'b0};
        vecs[19] = '{16'h0014, 1'b1, 16'h0024, 1'b1, 16'h0400, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0304, 1'b1};
        vecs[20] = '{16'h0014, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[21] = '{16'h0024, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[22] = '{16'h0080, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};

        rst = 1'b0;
        ifPc = 16'h0040; updValid = 1'b0; updPc = '0; updTaken = 1'b0; updTarget = '0;
        updPredTaken = 1'b0; updPredTarget = '0; bpClear = 1'b0;
        modelReset();
        #12;
        check("reset.taken",  64'(bpTaken),    64'd0);
        check("reset.target", 64'(predTarget), 64'd0);
        check("reset.perfBr", 64'(perfBr),     64'd0);
        check("reset.perfMis", 64'(perfMis),   64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 23; i++) begin
            ifPc = vecs[i].ifPc; updValid = vecs[i].uv; updPc = vecs[i].upc;
            updTaken = vecs[i].ut; updTarget = vecs[i].utgt; updPredTaken = vecs[i].upt;
            updPredTarget = vecs[i].uptgt; bpClear = vecs[i].clr;
            #1;
            check($sformatf("vec%0d.taken", i),  64'(bpTaken),    64'(vecs[i].expBp));
            check($sformatf("vec%0d.target", i), 64'(predTarget), 64'(vecs[i].expTgt));
            check($sformatf("vec%0d.misp", i),   64'(mispredict), 64'(vecs[i].expMisp));
            checkAndClock($sformatf("vec%0d.model", i));
        end
        #1;
        check("table.perfBr",   64'(perfBr),  64'd13);
        check("table.perfMis",  64'(perfMis), 64'd9);
        check("table.perfBr4",  64'(perfBr4), 64'd13);
        check("table.perfMis4", 64'(perfMis4), 64'd9);

        for (int n = 0; n < 400; n++) begin
            ifPc      = randPc();
            updValid  = ($urandom_range(0, 3) != 0);
            updPc     = ($urandom_range(0, 7) == 0) ? ifPc : randPc();
            updTaken  = 1'($urandom_range(0, 1));
            updTarget = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                modelLookup(int'(updPc), pt, ptg);
                updPredTaken  = pt;
                updPredTarget = 16'(ptg);
            end else begin
                updPredTaken  = 1'($urandom_range(0, 1));
                updPredTarget = 16'($urandom);
            end
            bpClear = ($urandom_range(0, 63) == 0);
            #1;
            checkAndClock($sformatf("rand%0d", n));
        end
        #1;
        check("sat.perfBr4", 64'(perfBr4), 64'hF);

        // Reset arriving while an allocating update is on the inputs.
        ifPc = 16'h0058; updValid = 1'b1; updPc = 16'h0058; updTaken = 1'b1;
        updTarget = 16'h0500; updPredTaken = 1'b0; updPredTarget = '0; bpClear = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("asyncRst.perfBr", 64'(perfBr),  64'd0);
        check("asyncRst.taken",  64'(bpTaken), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        updValid = 1'b0;
        modelReset();
        #1;
        check("rstMid.taken",   64'(bpTaken),    64'd0);
        check("rstMid.misp",    64'(mispredict), 64'd0);
        check("rstMid.perfMis", 64'(perfMis),    64'd0);
        checkAndClock("postRst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
